rom_copy_ctrl: RTL and testbench

- Sequencer that streams a block of bytes from the synchronous source ROM (cs/adr/data, 1-cycle read latency) into the destination memory (output ROM/RAM image).
- Software/top-level FSM issues a start pulse with base addresses and length; the block reads, buffers and writes one byte per clock and honours destination back-pressure.
- Sits between the message ROM and the Morse encoder output store; replaces ad-hoc bench copy loops.

---
 rtl/rom_copy_pkg.sv | 8 +
 rtl/copy_skid_fifo.sv | 44 ++++
 rtl/rom_copy_ctrl.sv | 95 +++++++++
 tb/tb_rom_copy_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_copy_pkg.sv
// rom_copy_pkg: shared widths, FSM states and the NUL terminator byte for rom_copy_ctrl
package rom_copy_pkg;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 13;
  localparam logic [7:0] NUL_BYTE = 8'h00;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
endpackage

// File: rtl/copy_skid_fifo.sv
// copy_skid_fifo: 2-entry FIFO carrying a data byte and its block index; clr_i flushes and wins over push
module copy_skid_fifo #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [1:0]        occ_o
);
  logic [DATA_W-1:0] data_q [2];
  logic [IDX_W-1:0]  idx_q [2];
  logic              wr_q, rd_q;
  logic [1:0]        occ_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q <= '{default: '0};
      idx_q  <= '{default: '0};
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      occ_q  <= '0;
    end else if (clr_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_q] <= data_i;
        idx_q[wr_q]  <= idx_i;
      end
      wr_q  <= wr_q ^ push_i;
      rd_q  <= rd_q ^ pop_i;
      occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
    end
  assign data_o = data_q[rd_q];
  assign idx_o  = idx_q[rd_q];
  assign occ_o  = occ_q;
endmodule

// File: rtl/rom_copy_ctrl.sv
// rom_copy_ctrl: streams a block from the 1-cycle-latency source ROM into destination memory at 1 byte/clock.
// Define COPY_STOP_ON_NUL_EN to end the copy right after an accepted 0x00 byte.
module rom_copy_ctrl
  import rom_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count,
  output logic              src_cs,
  output logic [ADDR_W-1:0] src_adr,
  input  logic [DATA_W-1:0] src_data,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_adr,
  output logic [DATA_W-1:0] dst_data,
  input  logic              dst_rdy
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_base_q, dst_base_q;
  logic [LEN_W-1:0]  len_q, rd_idx_q, count_q, head_idx;
  logic [DATA_W-1:0] head_data;
  logic              inflight_q;
  logic [1:0]        occ;
  logic [2:0]        level;
  logic              accept, pop, issue, last, nul_stop;
  assign accept = state_q == IDLE && start;
  assign pop    = dst_we && dst_rdy;
  // buffered-after-this-cycle plus the read in flight must leave room for one more
  assign level  = 3'(occ) + 3'(inflight_q) - 3'(pop);
`ifdef COPY_STOP_ON_NUL_EN
  assign nul_stop = pop && head_data == DATA_W'(NUL_BYTE);
`else
  assign nul_stop = 1'b0;
`endif
  assign issue = state_q == RUN && rd_idx_q < len_q && level < 3'd2 && !nul_stop;
  assign last  = pop && count_q + LEN_W'(1) == len_q;
  copy_skid_fifo #(.DATA_W(DATA_W), .IDX_W(LEN_W)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (nul_stop),
    .push_i (inflight_q),
    .data_i (src_data),
    .idx_i  (rd_idx_q - LEN_W'(1)),
    .pop_i  (pop),
    .data_o (head_data),
    .idx_o  (head_idx),
    .occ_o  (occ)
  );
  always_comb begin
    state_d = state_q;
    if (accept) state_d = length == '0 ? FIN : RUN;
    else if (state_q == RUN && (last || nul_stop)) state_d = FIN;
    else if (state_q == FIN) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      rd_idx_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        src_base_q <= src_base;
        dst_base_q <= dst_base;
        len_q      <= length;
        rd_idx_q   <= '0;
        count_q    <= '0;
      end else begin
        rd_idx_q <= rd_idx_q + LEN_W'(issue);
        count_q  <= count_q + LEN_W'(pop);
      end
    end
  assign busy     = state_q != IDLE;
  assign done     = state_q == FIN;
  assign count    = count_q;
  assign src_cs   = issue;
  assign src_adr  = issue ? src_base_q + ADDR_W'(rd_idx_q) : '0;
  assign dst_we   = occ != 2'd0;
  assign dst_adr  = dst_we ? dst_base_q + ADDR_W'(head_idx) : '0;
  assign dst_data = dst_we ? head_data : '0;
endmodule

// File: tb/tb_rom_copy_ctrl.sv
// tb_rom_copy_ctrl: scoreboard bench for rom_copy_ctrl; expected writes queued at start, checked as accepted
module tb_rom_copy_ctrl;
  typedef struct packed {
    logic [16:0] adr;
    logic [7:0]  data;
  } wr_t;
  logic        clk, rst_n, start, busy, done, src_cs, dst_we, dst_rdy;
  logic [16:0] src_base, dst_base, src_adr, dst_adr;
  logic [12:0] length, count;
  logic [7:0]  src_data, dst_data;
  logic [7:0]  src_mem [0:131071];
  wr_t         exp_w[$];
  logic [16:0] obs_src[$];
  int          done_q[$];
  int          cyc = 0, t0 = 0, n_cmp = 0, n_bad = 0, n_wr = 0, first_wr = -1, max_occ = 0;
  logic        prev_stall;
  logic [16:0] prev_adr;
  logic [7:0]  prev_data;
  bit          to;

  rom_copy_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .length(length), .busy(busy), .done(done), .count(count), .src_cs(src_cs),
    .src_adr(src_adr), .src_data(src_data), .dst_we(dst_we), .dst_adr(dst_adr),
    .dst_data(dst_data), .dst_rdy(dst_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) src_data <= src_cs ? src_mem[src_adr] : 'x;

  task automatic clear_obs();
    exp_w.delete();
    obs_src.delete();
    done_q.delete();
    n_wr = 0;
    first_wr = -1;
    max_occ = 0;
    prev_stall = 1'b0;
  endtask

  task automatic tick(input logic rdy);
    wr_t e;
    dst_rdy = rdy;
    @(negedge clk);
    if (rst_n) begin
      if (dst_we && dst_rdy) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc - t0;
        n_cmp++;
        if (exp_w.size() == 0) begin
          n_bad++;
          $display("FAIL wr_extra: got adr=%h data=%h, required no write", dst_adr, dst_data);
        end else begin
          e = exp_w.pop_front();
          if ({dst_adr, dst_data} !== {e.adr, e.data}) begin
            n_bad++;
            $display("FAIL wr_data: got adr=%h data=%h, required adr=%h data=%h", dst_adr, dst_data, e.adr, e.data);
          end
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if ({dst_we, dst_adr, dst_data} !== {1'b1, prev_adr, prev_data}) begin
          n_bad++;
          $display("FAIL stall_hold: got we=%b adr=%h data=%h, required we=1 adr=%h data=%h", dst_we, dst_adr, dst_data, prev_adr, prev_data);
        end
      end
      prev_stall = dst_we && !dst_rdy;
      prev_adr = dst_adr;
      prev_data = dst_data;
      if (src_cs) obs_src.push_back(src_adr);
      if (done) done_q.push_back(cyc - t0);
      if (int'(u_dut.occ) > max_occ) max_occ = int'(u_dut.occ);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [16:0] s, input logic [16:0] d, input logic [12:0] n, input int nexp);
    for (int i = 0; i < nexp; i++) exp_w.push_back({17'(d + 17'(i)), src_mem[17'(s + 17'(i))]});
    start = 1'b1;
    src_base = s;
    dst_base = d;
    length = n;
    t0 = cyc;
    tick(1'b1);
    start = 1'b0;
  endtask

  task automatic wait_done(input logic [3:0] pat, input int max, output bit timeout);
    int n = 0;
    while (done_q.size() == 0 && n < max) begin
      tick(pat[(cyc - t0) % 4]);
      n++;
    end
    timeout = done_q.size() == 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; length = '0; dst_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy, done, src_cs, dst_we} !== 4'b0) begin n_bad++; $display("FAIL rst_ctrl: got %b, required 0000", {busy, done, src_cs, dst_we}); end
    n_cmp++; if (count !== 13'd0) begin n_bad++; $display("FAIL rst_count: got %0d, required 0", count); end
    n_cmp++; if (src_adr !== 17'd0) begin n_bad++; $display("FAIL rst_src_adr: got %h, required 0", src_adr); end
    n_cmp++; if ({dst_adr, dst_data} !== 25'd0) begin n_bad++; $display("FAIL rst_dst: got %h/%h, required 0/0", dst_adr, dst_data); end
    rst_n = 1'b1;
    tick(1'b1);
  endtask

  task automatic test_basic();
    clear_obs();
    go(17'h0, 17'h100, 13'd50, 50);
    wait_done(4'hF, 200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout: no done in 200 cycles, required done"); end
    n_cmp++; if (first_wr !== 3) begin n_bad++; $display("FAIL basic_first_we: got cycle %0d, required 3", first_wr); end
    n_cmp++; if (done_q[0] !== 53) begin n_bad++; $display("FAIL basic_done_cyc: got %0d, required 53", done_q[0]); end
    n_cmp++; if (n_wr !== 50 || exp_w.size() !== 0) begin n_bad++; $display("FAIL basic_writes: got %0d (left %0d), required 50 (left 0)", n_wr, exp_w.size()); end
    n_cmp++; if (count !== 13'd50) begin n_bad++; $display("FAIL basic_count: got %0d, required 50", count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_zero_len();
    clear_obs();
    go(17'h10, 17'h20, 13'd0, 0);
    start = 1'b1;
    length = 13'd3;
    tick(1'b1);
    start = 1'b0;
    length = '0;
    repeat (6) tick(1'b1);
    n_cmp++; if (done_q.size() !== 1 || done_q[0] !== 1) begin n_bad++; $display("FAIL zero_done: got %0d pulses first at %0d, required 1 at 1", done_q.size(), done_q[0]); end
    n_cmp++; if (obs_src.size() !== 0 || n_wr !== 0) begin n_bad++; $display("FAIL zero_access: got %0d reads %0d writes, required 0/0", obs_src.size(), n_wr); end
    n_cmp++; if ({busy, count} !== 14'd0) begin n_bad++; $display("FAIL zero_state: got busy=%b count=%0d, required 0/0", busy, count); end
  endtask

  task automatic test_backpressure();
    clear_obs();
    go(17'h300, 17'h400, 13'd8, 8);
    wait_done(4'b1001, 200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL bp_timeout: no done in 200 cycles, required done"); end
    n_cmp++; if (n_wr !== 8 || exp_w.size() !== 0) begin n_bad++; $display("FAIL bp_writes: got %0d (left %0d), required 8 (left 0)", n_wr, exp_w.size()); end
    n_cmp++; if (max_occ > 2) begin n_bad++; $display("FAIL bp_occ: got %0d, required <=2", max_occ); end
    n_cmp++; if (count !== 13'd8) begin n_bad++; $display("FAIL bp_count: got %0d, required 8", count); end
  endtask

  task automatic test_wrap();
    logic [16:0] exp_a [4];
    exp_a = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
    clear_obs();
    go(17'h1FFFE, 17'h1FFFF, 13'd4, 4);
    wait_done(4'hF, 100, to);
    n_cmp++; if (obs_src.size() !== 4) begin n_bad++; $display("FAIL wrap_reads: got %0d, required 4", obs_src.size()); end
    for (int i = 0; i < 4 && i < obs_src.size(); i++) begin
      n_cmp++; if (obs_src[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_src_adr%0d: got %h, required %h", i, obs_src[i], exp_a[i]); end
    end
    n_cmp++; if (n_wr !== 4 || exp_w.size() !== 0 || done_q[0] !== 7) begin n_bad++; $display("FAIL wrap_writes: got %0d writes done@%0d, required 4 done@7", n_wr, done_q[0]); end
  endtask

  task automatic test_start_while_busy();
    clear_obs();
    go(17'h40, 17'h800, 13'd6, 6);
    tick(1'b1);
    start = 1'b1; src_base = 17'h1000; dst_base = 17'h2000; length = 13'd2;
    tick(1'b1);
    start = 1'b0;
    wait_done(4'hF, 100, to);
    repeat (4) tick(1'b1);
    n_cmp++; if (done_q.size() !== 1 || done_q[0] !== 9) begin n_bad++; $display("FAIL busy_done: got %0d pulses first at %0d, required 1 at 9", done_q.size(), done_q[0]); end
    n_cmp++; if (n_wr !== 6 || exp_w.size() !== 0 || count !== 13'd6) begin n_bad++; $display("FAIL busy_writes: got %0d count=%0d, required 6/6", n_wr, count); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    go(17'h0, 17'h100, 13'd50, 50);
    repeat (9) tick(1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, src_cs, dst_we, count, src_adr, dst_adr, dst_data} !== '0) begin n_bad++; $display("FAIL mid_rst_outs: got busy=%b we=%b cs=%b count=%0d, required all 0", busy, dst_we, src_cs, count); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
    repeat (60) tick(1'b1);
    n_cmp++; if (done_q.size() !== 0 || n_wr !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d done %0d writes, required 0/0", done_q.size(), n_wr); end
    go(17'h50, 17'h900, 13'd5, 5);
    wait_done(4'hF, 100, to);
    n_cmp++; if (to || n_wr !== 5 || exp_w.size() !== 0 || count !== 13'd5) begin n_bad++; $display("FAIL mid_recopy: got to=%b writes=%0d count=%0d, required 0/5/5", to, n_wr, count); end
  endtask

  task automatic test_nul();
    int nexp, dcyc;
    logic [7:0] msg [7];
    msg = '{8'h53, 8'h4F, 8'h53, 8'h00, 8'h58, 8'h59, 8'h5A};
    for (int i = 0; i < 7; i++) src_mem[17'h200 + i] = msg[i];
`ifdef COPY_STOP_ON_NUL_EN
    nexp = 4; dcyc = 7;
`else
    nexp = 7; dcyc = 10;
`endif
    clear_obs();
    go(17'h200, 17'h300, 13'd7, nexp);
    wait_done(4'hF, 100, to);
    repeat (4) tick(1'b1);
    n_cmp++; if (to || done_q[0] !== dcyc) begin n_bad++; $display("FAIL nul_done: got to=%b done@%0d, required done@%0d", to, done_q[0], dcyc); end
    n_cmp++; if (n_wr !== nexp || exp_w.size() !== 0) begin n_bad++; $display("FAIL nul_writes: got %0d, required %0d", n_wr, nexp); end
    n_cmp++; if (count !== 13'(nexp)) begin n_bad++; $display("FAIL nul_count: got %0d, required %0d", count, nexp); end
  endtask

  initial begin
    for (int a = 0; a < 131072; a++) src_mem[a] = 8'((a * 37 + 11) % 255 + 1);
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_wrap();
    test_start_while_busy();
    test_reset_mid();
    test_nul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
